freq_div_ctrl: RTL
==================

FREQ_DIV_CTRL -- requirements
Module: freq_div_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, divisor and counter width in bits.
REQ-002 SHALL have port clock  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port enable  input  1  request divided-clock generation.
REQ-005 SHALL have port cfg_valid  input  1  new divisor offered.
REQ-006 SHALL have port cfg_div  input  CNT_W  divisor N; output period = N clock cycles.
REQ-007 SHALL have port cfg_ready  output  1  divisor can be accepted this cycle.
REQ-008 SHALL have port cfg_err  output  1  one-cycle pulse: accepted divisor rejected (N<2).
REQ-009 SHALL have port out_clock  output  1  registered divided clock.
REQ-010 SHALL have port tick  output  1  one-cycle pulse on first cycle of each output period.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL implement states IDLE, RUN, STOP; internal count (CNT_W bits), div_reg, pending flag, pending_div.
REQ-013 IDLE: count=0, out_clock=0, tick=0; enable=1 sampled -> RUN on next edge with count=0, out_clock=1, tick=1 (1-cycle latency).
REQ-014 RUN/STOP: count increments each cycle, wraps to 0 after div_reg-1; tick=1 exactly when count=0.
REQ-015 out_clock SHALL be 1 when count < (div_reg>>1), else 0; N=2 gives 1,0; N=3 gives 1,0,0; N=4 gives 1,1,0,0.
REQ-016 cfg handshake completes when cfg_valid && cfg_ready; cfg_ready = !pending.
REQ-017 Accepted N<2: not stored, cfg_err=1 next cycle, div_reg unchanged, cfg_ready stays 1.
REQ-018 Accepted N>=2 in IDLE: div_reg=N on next edge, no pending.
REQ-019 Accepted N>=2 in RUN/STOP: pending=1, pending_div=N; applied at wrap (count=div_reg-1), so next period (count=0) uses N; pending cleared same edge.
REQ-020 cfg_ready SHALL return to 1 the cycle after pending is applied; offers during pending are not accepted.
REQ-021 Accepted divisor with wrap in the same cycle: stored as pending, applied at the following wrap.
REQ-022 enable=0 in RUN -> STOP; current period completes unchanged.
REQ-023 STOP at wrap: enable=1 -> RUN with count=0, tick=1 (no gap); enable=0 -> IDLE, out_clock=0, busy=0; pending divisor applied before entering IDLE.
REQ-024 enable=1 in STOP before wrap -> RUN immediately, count continues.
REQ-025 Maximum divisor 2^CNT_W-1; no other arithmetic overflow possible.

Reset
REQ-026 reset=1 SHALL on the same edge force: state=IDLE, count=0, div_reg=2, pending=0, out_clock=0, tick=0, busy=0, cfg_err=0, cfg_ready=1.
REQ-027 reset mid-operation SHALL discard pending divisor; reset overrides enable and cfg_valid.

Configuration
REQ-028 Macro FREQ_DIV_CTRL_PERIOD_CNT_EN defined: adds output period_cnt [15:0], +1 on each tick, wraps 0xFFFF->0x0000, cleared by reset.
REQ-029 Macro undefined: port period_cnt absent; all other behaviour identical.

Verification
REQ-030 Reset, enable=1, default div -> out_clock 1,0,1,0..., tick every 2nd cycle, first tick 1 cycle after enable.
REQ-031 In IDLE write N=5, enable -> out_clock 1,1,0,0,0 repeating, tick period 5.
REQ-032 RUN N=4, write N=6 mid-period -> cfg_ready=0 until wrap, current period 4 cycles, next periods 6 cycles.
REQ-033 Write N=1 and N=0 -> cfg_err pulse each, div_reg unchanged, cfg_ready stays 1.
REQ-034 RUN N=8, drop enable at count=2 -> 5 more cycles then IDLE, busy=0, out_clock=0; re-enable in STOP -> no gap.
REQ-035 Assert reset at count=3 with pending divisor -> all outputs at reset values next edge, div_reg=2; with FREQ_DIV_CTRL_PERIOD_CNT_EN, period_cnt=0.

Source files
------------

// File: rtl/freq_div_ctrl.sv
// freq_div_ctrl: programmable clock divider with a registered divided clock,
// a period-start tick, and a ready/valid divisor update that takes effect
// only on a period boundary while running.
// Optional feature macro: FREQ_DIV_CTRL_PERIOD_CNT_EN adds a 16-bit period_cnt
// output that counts ticks.
module freq_div_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             out_clock,
    output logic             tick,
`ifdef FREQ_DIV_CTRL_PERIOD_CNT_EN
    output logic [15:0]      period_cnt,
`endif
    output logic             busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic             out_clock_q, out_clock_d;
    logic             tick_q, tick_d;
    logic             cfg_err_q, cfg_err_d;
    logic             busy_d;
    logic             accept;
    logic             wrap;

    assign accept = cfg_valid && !pend_q;
    assign wrap   = (count_q == div_q - CNT_W'(1));

    // Next-state: period counter, run/stop/idle sequencing, divisor update
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_div_d = pend_div_q;
        cfg_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                count_d = '0;
                // A divisor accepted on the last STOP cycle lands here
                if (pend_q) begin
                    div_d  = pend_div_q;
                    pend_d = 1'b0;
                end
                if (enable) state_d = ST_RUN;
            end
            ST_RUN, ST_STOP: begin
                if (wrap) begin
                    count_d = '0;
                    if (pend_q) begin
                        div_d  = pend_div_q;
                        pend_d = 1'b0;
                    end
                    if (enable)                 state_d = ST_RUN;
                    else if (state_q == ST_RUN) state_d = ST_STOP;
                    else                        state_d = ST_IDLE;
                end else begin
                    count_d = count_q + CNT_W'(1);
                    state_d = enable ? ST_RUN : ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase

        // Divisor handshake; while running it waits for the next boundary
        if (accept) begin
            if (cfg_div < CNT_W'(2)) begin
                cfg_err_d = 1'b1;
            end else if (state_q == ST_IDLE) begin
                div_d = cfg_div;
            end else begin
                pend_d     = 1'b1;
                pend_div_d = cfg_div;
            end
        end

        busy_d      = (state_d != ST_IDLE);
        out_clock_d = busy_d && (count_d < (div_d >> 1));
        tick_d      = busy_d && (count_d == '0);
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            div_q       <= CNT_W'(2);
            pend_q      <= 1'b0;
            pend_div_q  <= '0;
            out_clock_q <= 1'b0;
            tick_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            div_q       <= div_d;
            pend_q      <= pend_d;
            pend_div_q  <= pend_div_d;
            out_clock_q <= out_clock_d;
            tick_q      <= tick_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

`ifdef FREQ_DIV_CTRL_PERIOD_CNT_EN
    logic [15:0] period_cnt_q, period_cnt_d;

    // Count presented ticks; wraps naturally at 16 bits
    always_comb begin
        period_cnt_d = period_cnt_q + {15'd0, tick_q};
    end

    // Tick counter register
    always_ff @(posedge clock) begin
        if (reset) period_cnt_q <= '0;
        else       period_cnt_q <= period_cnt_d;
    end

    assign period_cnt = period_cnt_q;
`endif

    assign cfg_ready = !pend_q;
    assign cfg_err   = cfg_err_q;
    assign out_clock = out_clock_q;
    assign tick      = tick_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
